// File: rtl/bird_column.sv
// Vertical position tracker for the Flappy Bird player: a one-hot 16-row column
// that climbs or falls one row per move tick and saturates at the ceiling and floor.
module bird_column #(
   parameter int unsigned MOVE_PERIOD = 1,
   parameter int unsigned START_ROW   = 8,
   parameter int unsigned BIRD_COL    = 12
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              up,
   input  logic              Over,
   output logic [15:0][15:0] RedPixels,
   output logic [15:0]       birdState
);

   localparam int unsigned     CNT_W     = (MOVE_PERIOD > 1) ? $clog2(MOVE_PERIOD) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MOVE_PERIOD - 1);
   localparam logic [15:0]      START_POS = 16'(1) << START_ROW;
   localparam logic [3:0]       COL_IDX   = 4'(BIRD_COL);

   logic [CNT_W-1:0] div_q, div_d;
   logic [15:0]      pos_q, pos_d;
   logic             tick;

   always_comb begin
      tick  = (div_q == LAST_CNT);
      div_d = tick ? '0 : div_q + CNT_W'(1);
      pos_d = pos_q;
      if (tick && !Over) begin
         // Row 15 ORs in itself on a climb and row 0 on a fall, so the bird sticks at the edges.
         if (up) pos_d = {pos_q[14:0], 1'b0} | {pos_q[15], 15'b0};
         else    pos_d = {1'b0, pos_q[15:1]} | {15'b0, pos_q[0]};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pos_q <= START_POS;
         div_q <= '0;
      end else begin
         pos_q <= pos_d;
         div_q <= div_d;
      end
   end

   always_comb begin
      RedPixels          = '0;
      RedPixels[COL_IDX] = pos_q;
      birdState          = pos_q;
   end

endmodule

// File: tb/tb_bird_column.sv
// Self-checking bench for bird_column: directed scenarios plus randomized play
// compared against a row-index model, for MOVE_PERIOD of 1 and 4.
module tb_bird_column;

   typedef logic [15:0][15:0] plane_t;

   logic        clk   = 1'b0;
   logic        reset = 1'b0;
   logic        up    = 1'b0;
   logic        Over  = 1'b0;
   plane_t      red1, red4;
   logic [15:0] bs1, bs4;

   int checks = 0;
   int errors = 0;
   int row1 = 8;
   int row4 = 8;
   int n4   = 0;

   always #5 clk = ~clk;

   bird_column u_dut (
      .clk(clk), .reset(reset), .up(up), .Over(Over),
      .RedPixels(red1), .birdState(bs1)
   );

   bird_column #(.MOVE_PERIOD(4)) u_dut4 (
      .clk(clk), .reset(reset), .up(up), .Over(Over),
      .RedPixels(red4), .birdState(bs4)
   );

   function automatic int move_row(input int row, input logic dir_up);
      if (dir_up) return (row < 15) ? row + 1 : 15;
      else        return (row > 0)  ? row - 1 : 0;
   endfunction

   function automatic plane_t plane(input int row);
      plane_t p;
      p     = '0;
      p[12] = 16'(1) << row;
      return p;
   endfunction

   // Drive one clock edge and advance the reference rows.
   task automatic step(input logic u, input logic o, input logic r);
      up = u; Over = o; reset = r;
      @(posedge clk);
      #1;
      if (r) begin
         row1 = 8; row4 = 8; n4 = 0;
      end else begin
         if (!o) row1 = move_row(row1, u);
         if (!o && (n4 % 4) == 3) row4 = move_row(row4, u);
         n4++;
      end
      reset = 1'b0;
   endtask

   task automatic test_reset;
      step(1'b0, 1'b0, 1'b1);
      checks++;
      if (bs1 !== 16'h0100) begin errors++; $display("FAIL reset_bird got=%h exp=%h", bs1, 16'h0100); end
      checks++;
      if (bs4 !== 16'h0100) begin errors++; $display("FAIL reset_bird_p4 got=%h exp=%h", bs4, 16'h0100); end
      checks++;
      if (red1 !== plane(8)) begin errors++; $display("FAIL reset_plane got=%h exp=%h", red1, plane(8)); end
   endtask

   task automatic test_fall;
      logic [15:0] exp_seq [3] = '{16'h0080, 16'h0040, 16'h0020};
      step(1'b0, 1'b0, 1'b1);
      for (int k = 0; k < 3; k++) begin
         step(1'b0, 1'b0, 1'b0);
         checks++;
         if (bs1 !== exp_seq[k]) begin errors++; $display("FAIL fall[%0d] got=%h exp=%h", k, bs1, exp_seq[k]); end
      end
   endtask

   task automatic test_top_sat;
      logic [15:0] exp;
      step(1'b1, 1'b0, 1'b1);
      for (int k = 1; k <= 10; k++) begin
         step(1'b1, 1'b0, 1'b0);
         exp = 16'(1) << ((8 + k > 15) ? 15 : 8 + k);
         checks++;
         if (bs1 !== exp) begin errors++; $display("FAIL climb[%0d] got=%h exp=%h", k, bs1, exp); end
      end
      step(1'b0, 1'b0, 1'b0);
      checks++;
      if (bs1 !== 16'h4000) begin errors++; $display("FAIL top_drop got=%h exp=%h", bs1, 16'h4000); end
   endtask

   task automatic test_floor_sat;
      logic [15:0] exp;
      step(1'b0, 1'b0, 1'b1);
      for (int k = 1; k <= 12; k++) begin
         step(1'b0, 1'b0, 1'b0);
         exp = 16'(1) << ((8 - k < 0) ? 0 : 8 - k);
         checks++;
         if (bs1 !== exp) begin errors++; $display("FAIL floor[%0d] got=%h exp=%h", k, bs1, exp); end
      end
   endtask

   task automatic test_over_freeze;
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      checks++;
      if (bs1 !== 16'h0040) begin errors++; $display("FAIL pre_over got=%h exp=%h", bs1, 16'h0040); end
      for (int k = 0; k < 4; k++) begin
         step(logic'(k % 2), 1'b1, 1'b0);
         checks++;
         if (bs1 !== 16'h0040) begin errors++; $display("FAIL over_hold[%0d] got=%h exp=%h", k, bs1, 16'h0040); end
      end
      step(1'b1, 1'b0, 1'b0);
      checks++;
      if (bs1 !== 16'h0080) begin errors++; $display("FAIL over_release got=%h exp=%h", bs1, 16'h0080); end
   endtask

   task automatic test_midreset;
      step(1'b0, 1'b0, 1'b1);
      for (int k = 0; k < 7; k++) step(1'b0, 1'b0, 1'b0);
      checks++;
      if (bs1 !== 16'h0002) begin errors++; $display("FAIL low_pos got=%h exp=%h", bs1, 16'h0002); end
      step(1'b0, 1'b1, 1'b1);
      checks++;
      if (bs1 !== 16'h0100) begin errors++; $display("FAIL midreset got=%h exp=%h", bs1, 16'h0100); end
      checks++;
      if (red1[12] !== bs1) begin errors++; $display("FAIL col12_match got=%h exp=%h", red1[12], bs1); end
      checks++;
      if (red1 !== plane(8)) begin errors++; $display("FAIL midreset_plane got=%h exp=%h", red1, plane(8)); end
   endtask

   task automatic test_period4;
      logic [15:0] exp;
      step(1'b0, 1'b0, 1'b1);
      for (int k = 1; k <= 9; k++) begin
         step(1'b0, 1'b0, 1'b0);
         exp = 16'(1) << (8 - k / 4);
         checks++;
         if (bs4 !== exp) begin errors++; $display("FAIL p4[%0d] got=%h exp=%h", k, bs4, exp); end
         checks++;
         if ($countones(bs4) != 1) begin errors++; $display("FAIL p4_onehot[%0d] got=%0d exp=1", k, $countones(bs4)); end
      end
   endtask

   task automatic test_random;
      logic r, o, u;
      for (int k = 0; k < 300; k++) begin
         r = ($urandom_range(0, 99) < 3);
         o = ($urandom_range(0, 99) < 20);
         u = logic'($urandom_range(0, 1));
         step(u, o, r);
         checks++;
         if (red1 !== plane(row1)) begin errors++; $display("FAIL rand_p1[%0d] got=%h exp=%h", k, red1, plane(row1)); end
         checks++;
         if (bs1 !== 16'(1) << row1) begin errors++; $display("FAIL rand_bs1[%0d] got=%h exp=%h", k, bs1, 16'(1) << row1); end
         checks++;
         if (red4 !== plane(row4)) begin errors++; $display("FAIL rand_p4[%0d] got=%h exp=%h", k, red4, plane(row4)); end
         checks++;
         if (bs4 !== 16'(1) << row4) begin errors++; $display("FAIL rand_bs4[%0d] got=%h exp=%h", k, bs4, 16'(1) << row4); end
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset;
      test_fall;
      test_top_sat;
      test_floor_sat;
      test_over_freeze;
      test_midreset;
      test_period4;
      test_random;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bird_column.md
Name: bird_column

Overview:
- Vertical position tracker for the player "bird" in the 16x16 LED Flappy Bird game.
- Holds a one-hot 16-bit column built from per-row cells: a generic cell, a top-saturating cell, a bottom-saturating cell, and a reset-lit start cell at row 8.
- Each move tick the bird climbs one row while `up` is high and falls one row while `up` is low. It freezes while `Over` is asserted.
- Drives column 12 of the red pixel plane and exports the column as `birdState` for collision logic.

Parameters:
- MOVE_PERIOD, default 1: clock cycles per move tick. 1 means the bird moves every cycle. Legal range is 1 to 2^16.
- START_ROW, default 8: row index lit after reset.
- BIRD_COL, default 12: column of RedPixels driven by the bird.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  synchronous, active-high reset.
- up  input  1  level: 1 = climb, 0 = fall. Sampled on move ticks.
- Over  input  1  game-over freeze, active-high.
- RedPixels  output  [15:0][15:0]  red plane, indexed [column][row]. Only [BIRD_COL] is driven; all other bits are constant 0.
- birdState  output  16  equals RedPixels[BIRD_COL]; bit 15 is top, bit 0 is bottom.

Behaviour:
- State is a 16-bit register `pos`, one bit per row cell, updated only on rising clk.
- Reset (synchronous, highest priority, overrides Over and up):
  - pos = 1<<START_ROW, i.e. 16'h0100 at default.
  - Tick divider is cleared.
  - Next cycle: birdState = 16'h0100.
- Tick generation: tick is asserted on one cycle every MOVE_PERIOD cycles. With MOVE_PERIOD=1, tick is constant 1. The divider counts only when not in reset.
- Per-cell next state on a tick with Over=0:
  - Generic row i (1..14): up=1 gives pos[i] <= pos[i-1] (lit from below). up=0 gives pos[i] <= pos[i+1] (lit from above).
  - Top row 15: up=1 gives pos[15] <= pos[14] | pos[15], so it saturates at the ceiling. up=0 gives pos[15] <= 0, because the above-neighbour is tied 0.
  - Bottom row 0: up=0 gives pos[0] <= pos[1] | pos[0], so it saturates at the floor. up=1 gives pos[0] <= 0, because the below-neighbour is tied 0.
  - Start row (START_ROW) follows the generic rule; it differs only in its reset value of 1.
- Over=1 (and not reset): every cell holds its value. Over does not stop the tick divider.
- Non-tick cycles: all cells hold.
- Invariant: exactly one bit of pos is set at all times after the first reset. Nothing clears the bird at an edge; collision and floor death are decided outside this block.
- Outputs are registered with no extra latency:
  - birdState reflects pos immediately after the clock edge.
  - `up` sampled at edge k affects birdState visibly after edge k.
- Before the first reset pos is undefined; no power-on value is required.
- Mid-operation reset: the bird returns to START_ROW on the next edge regardless of position or Over.

Test Plan:
1. Reset, then up=0, Over=0, 3 cycles. birdState goes 16'h0100 → 16'h0080 → 16'h0040 → 16'h0020.
2. Reset, then up=1 for 10 cycles. birdState climbs 0x0200, 0x0400, … 0x8000 after 7 cycles, then stays 16'h8000 (top saturation). Then up=0 for 1 cycle gives 16'h4000.
3. Reset, then up=0 for 12 cycles. The bird reaches 16'h0001 after 8 cycles and holds 16'h0001 (floor saturation) thereafter.
4. Reset, up=0 for 2 cycles (16'h0040), then Over=1 with up toggling for 4 cycles. birdState stays 16'h0040. Over=0 with up=1 then gives 16'h0080.
5. Over=1 with the bird at 16'h0002, then reset=1 for 1 cycle. birdState = 16'h0100. Verify RedPixels[12] == birdState, and every other RedPixels column equals 0 throughout.
6. MOVE_PERIOD=4, reset, up=0. birdState changes only on every 4th cycle: 0x0100 is held for 3 cycles, then becomes 0x0080, held, then 0x0040. Check the one-hot invariant every cycle.
